bus_rx_endpoint: RTL and testbench
==================================

Name: bus_rx_endpoint

Overview:
Receiving terminal for one device port of the bus generator/arbiter (bs_gnrtr_n_rbtr).
- Samples the arbiter's push / D_push output.
- Keeps packets whose destination ID matches this terminal's ID or the broadcast ID.
- Buffers accepted packets in a first-word-fall-through FIFO.
- Presents them to the local device with the same pndng/pop convention the arbiter uses on its source side.
- One instance per device; drvrs instances sit behind the bus.

Parameters:
- pckg_sz, 16, packet width in bits; bits [pckg_sz-1 -: 8] carry the destination ID, the rest is payload.
- drvrs, 4, number of bus devices; legal my_id range is 0..drvrs-1.
- my_id, 0, this terminal's ID (8-bit value).
- broadcast, 8'hFF, ID accepted by every terminal.
- depth, 8, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  bus clock, all state on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- push  in  1  bus strobe: D_push valid this cycle.
- D_push  in  pckg_sz  packet from the bus.
- pndng  out  1  FIFO non-empty; D_pop valid.
- D_pop  out  pckg_sz  head-of-FIFO packet, full word with ID unchanged.
- pop  in  1  device consumes head this cycle; ignored when pndng=0.
- full  out  1  FIFO holds depth entries.
- ovf  out  1  sticky: a matching packet was dropped.
- ovf_clr  in  1  synchronous clear of ovf and drop_cnt.
- drop_cnt  out  8  matching packets dropped while full; saturates at 255.
- rx_cnt  out  16  accepted-packet counter; exists only with RX_STATS_EN, otherwise tied 0.

Behaviour:
- Reset values: pndng=0, D_pop=0, full=0, ovf=0, drop_cnt=0, rx_cnt=0; read/write pointers and occupancy count are 0. Reset asserted mid-transfer discards all FIFO content immediately; no partial packet survives.
- Match: id = D_push[pckg_sz-1 -: 8]; match = push & (id==my_id | id==broadcast). Non-matching pushes are ignored and never count as drops.
- Write: on posedge with match=1 and space available, store D_push at the write pointer, advance it modulo depth, increment occupancy.
- Space available means occupancy < depth, or occupancy == depth with pop=1 in the same cycle (pop frees the slot on that edge).
- Latency: a packet written on edge N gives pndng=1 and D_pop=packet after edge N. The device may pop it on edge N+1.
- Read: FWFT. D_pop always shows the head entry.
- Pop: on posedge with pop=1 and pndng=1, advance the read pointer and decrement occupancy. Pop while empty has no effect.
- Simultaneous push and pop:
  - When empty: only the write takes effect; pndng rises.
  - Otherwise: both take effect and occupancy is unchanged.
- full = (occupancy == depth), registered alongside occupancy.
- Drop: on match=1 without space available, the packet is discarded, ovf←1, and drop_cnt increments up to 255 and holds there.
- ovf_clr=1: ovf←0 and drop_cnt←0. If a drop occurs in the same cycle, the clear wins for ovf, and drop_cnt←1.
- Pointer wrap: pointers are log2(depth) bits and wrap naturally. Occupancy is log2(depth)+1 bits.
- No combinational path from push/D_push to any output.

Optional Feature:
Macro: RX_STATS_EN
- Defined: rx_cnt increments on every accepted write, wrapping modulo 2^16, and is cleared only by reset.
- Undefined: counter logic is not compiled; rx_cnt is driven constant 0. All other behaviour is identical.

Decomposition:
- Package bus_pkg:
  - ID_W=8 and BCAST_ID_DEF=8'hFF.
  - Function get_id(pkt) returning the top ID_W bits.
  - typedef for the drop counter (8-bit).
- Sub-module rx_fifo (parameters width, depth):
  - storage, pointers, occupancy, full/empty;
  - push/pop same-cycle rule as above.
- bus_rx_endpoint keeps the match, drop, ovf and stats logic.

Test Plan:
- my_id=2: push 16'h02AB, then 16'h03CD, then 16'hFF11 → FIFO holds 02AB then FF11. 03CD is ignored and drop_cnt stays 0.
- Push 16'h0201 on edge N → pndng=1 and D_pop=0201 after edge N. Pop at N+1 → pndng=0.
- depth=8: push 9 matching packets with no pop → full=1 after the 8th; the 9th is dropped, ovf=1, drop_cnt=1. Then push and pop in the same cycle while full → accepted; occupancy stays 8 and D_pop advances.
- 300 matching pushes while full → drop_cnt=255 (saturated). ovf_clr pulse → ovf=0, drop_cnt=0.
- Fill 5 entries, assert reset mid-stream → all outputs 0 immediately (asynchronous). Next push after deassertion appears as a fresh head.
- With RX_STATS_EN: 20 accepted plus 5 non-matching pushes → rx_cnt=20. Without the macro → rx_cnt=0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus constants, ID extraction helper and the drop-counter type.
package bus_pkg;

  localparam int ID_W      = 8;
  localparam int PKT_MAX_W = 64;
  localparam logic [ID_W-1:0] BCAST_ID_DEF = 8'hFF;

  typedef logic [7:0] drop_cnt_t;

  // Destination ID sits in the top ID_W bits of a pkt_w-bit packet.
  function automatic logic [ID_W-1:0] get_id(input logic [PKT_MAX_W-1:0] pkt, input int pkt_w);
    return ID_W'(pkt >> (pkt_w - ID_W));
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// First-word-fall-through FIFO; a pop on a full FIFO frees the slot for a same-edge write.
module rx_fifo #(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_i,
  input  logic [width-1:0] wdat_i,
  input  logic             rd_i,
  output logic [width-1:0] rdat_o,
  output logic             vld_o,
  output logic             full_o,
  output logic             space_o
);

  localparam int AW = $clog2(depth);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(depth);

  logic [width-1:0] mem_q [depth];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             do_rd, do_wr;

  always_comb begin
    do_rd   = rd_i && (cnt_q != '0);
    space_o = (cnt_q != DEPTH_C) || do_rd;
    do_wr   = wr_i && space_o;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    if (do_wr) wptr_d = wptr_q + AW'(1);
    if (do_rd) rptr_d = rptr_q + AW'(1);
    if (do_wr && !do_rd) begin
      cnt_d = cnt_q + (AW+1)'(1);
    end else if (!do_wr && do_rd) begin
      cnt_d = cnt_q - (AW+1)'(1);
    end
    full_d = (cnt_d == DEPTH_C);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wptr_q] <= wdat_i;
  end

  assign vld_o  = (cnt_q != '0);
  assign rdat_o = vld_o ? mem_q[rptr_q] : '0;
  assign full_o = full_q;

endmodule

// File: rtl/bus_rx_endpoint.sv
// Bus receive terminal: filters pushes by destination ID, buffers hits in an FWFT FIFO, tracks drops.
// Optional RX_STATS_EN adds a 16-bit accepted-packet counter on rx_cnt.
module bus_rx_endpoint
  import bus_pkg::*;
#(
  parameter int              pckg_sz   = 16,
  parameter int              drvrs     = 4,
  parameter logic [ID_W-1:0] my_id     = 8'd0,
  parameter logic [ID_W-1:0] broadcast = BCAST_ID_DEF,
  parameter int              depth     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  output logic               full,
  output logic               ovf,
  input  logic               ovf_clr,
  output drop_cnt_t          drop_cnt,
  output logic [15:0]        rx_cnt
);

  if ((int'(my_id) >= drvrs) && (my_id != broadcast)) begin : g_bad_id
    $error("bus_rx_endpoint: my_id outside 0..drvrs-1");
  end

  logic [ID_W-1:0] id;
  logic            match, space, accept, drop;
  logic            ovf_q, ovf_d;
  drop_cnt_t       drop_cnt_q, drop_cnt_d;

  assign id     = get_id(PKT_MAX_W'(D_push), pckg_sz);
  assign match  = push && ((id == my_id) || (id == broadcast));
  assign accept = match && space;
  assign drop   = match && !space;

  rx_fifo #(
    .width (pckg_sz),
    .depth (depth)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .wr_i    (match),
    .wdat_i  (D_push),
    .rd_i    (pop),
    .rdat_o  (D_pop),
    .vld_o   (pndng),
    .full_o  (full),
    .space_o (space)
  );

  // A clear coinciding with a drop still records that one drop in the counter.
  always_comb begin
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (ovf_clr) begin
      ovf_d      = 1'b0;
      drop_cnt_d = drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign ovf      = ovf_q;
  assign drop_cnt = drop_cnt_q;

`ifdef RX_STATS_EN
  logic [15:0] rx_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_cnt_q <= '0;
    end else if (accept) begin
      rx_cnt_q <= rx_cnt_q + 16'd1;
    end
  end

  assign rx_cnt = rx_cnt_q;
`else
  assign rx_cnt = '0;
`endif

endmodule

// File: tb/tb_bus_rx_endpoint.sv
// Randomized + directed bench for bus_rx_endpoint (my_id=2, depth=8) against a queue-based model.
module tb_bus_rx_endpoint;

  logic        clk = 1'b0;
  logic        reset;
  logic        push;
  logic [15:0] D_push;
  logic        pndng;
  logic [15:0] D_pop;
  logic        pop;
  logic        full;
  logic        ovf;
  logic        ovf_clr;
  logic [7:0]  drop_cnt;
  logic [15:0] rx_cnt;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mq[$];
  bit          m_ovf;
  int          m_drop;
  int          m_rx;

  always #5 clk = ~clk;

  bus_rx_endpoint #(
    .pckg_sz   (16),
    .drvrs     (4),
    .my_id     (8'd2),
    .broadcast (8'hFF),
    .depth     (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .D_push   (D_push),
    .pndng    (pndng),
    .D_pop    (D_pop),
    .pop      (pop),
    .full     (full),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr),
    .drop_cnt (drop_cnt),
    .rx_cnt   (rx_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_rx();
`ifdef RX_STATS_EN
    return m_rx;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
    m_rx   = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pndng"},    32'(pndng),    32'(mq.size() != 0));
    check({tag, ".D_pop"},    32'(D_pop),    (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
    check({tag, ".full"},     32'(full),     32'(mq.size() == 8));
    check({tag, ".ovf"},      32'(ovf),      32'(m_ovf));
    check({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
    check({tag, ".rx_cnt"},   32'(rx_cnt),   32'(exp_rx()));
  endtask

  // Queue-level view of one clock edge: hits go to the back, pops take the front.
  task automatic model_edge(input logic p, input logic [15:0] d, input logic pp, input logic clr);
    bit hit, pop_ok, room;
    hit    = p && (d[15:8] == 8'h02 || d[15:8] == 8'hFF);
    pop_ok = pp && (mq.size() > 0);
    room   = (mq.size() < 8) || pop_ok;
    if (pop_ok) void'(mq.pop_front());
    if (hit && room) begin
      mq.push_back(d);
      m_rx = (m_rx + 1) % 65536;
    end
    if (clr) begin
      m_ovf  = 1'b0;
      m_drop = (hit && !room) ? 1 : 0;
    end else if (hit && !room) begin
      m_ovf = 1'b1;
      if (m_drop < 255) m_drop++;
    end
  endtask

  task automatic step(input logic p, input logic [15:0] d, input logic pp, input logic clr);
    push = p; D_push = d; pop = pp; ovf_clr = clr;
    @(posedge clk);
    model_edge(p, d, pp, clr);
    #1;
    push = 1'b0; pop = 1'b0; ovf_clr = 1'b0;
    check_all("step");
  endtask

  initial begin
    logic [15:0] d;
    logic [7:0]  idb;
    reset = 1'b1; push = 1'b0; D_push = '0; pop = 1'b0; ovf_clr = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    reset = 1'b0;

    // ID filtering: own ID and broadcast kept, foreign ID ignored.
    step(1, 16'h02AB, 0, 0);
    step(1, 16'h03CD, 0, 0);
    step(1, 16'hFF11, 0, 0);
    check("filter.head", 32'(D_pop), 32'h02AB);
    check("filter.drop", 32'(drop_cnt), 32'd0);
    step(0, 16'h0000, 1, 0);
    check("filter.second", 32'(D_pop), 32'hFF11);
    step(0, 16'h0000, 1, 0);
    check("filter.empty", 32'(pndng), 32'd0);

    // One-edge latency, pop on the next edge.
    step(1, 16'h0201, 0, 0);
    check("lat.pndng", 32'(pndng), 32'd1);
    check("lat.dpop", 32'(D_pop), 32'h0201);
    step(0, 16'h0000, 1, 0);
    check("lat.popped", 32'(pndng), 32'd0);

    // Fill to full, overflow on the ninth.
    for (int i = 0; i < 9; i++) begin
      step(1, 16'h0200 + 16'(i), 0, 0);
      if (i == 7) check("fill.full8", 32'(full), 32'd1);
    end
    check("ovf.set", 32'(ovf), 32'd1);
    check("ovf.cnt1", 32'(drop_cnt), 32'd1);
    step(1, 16'h02EE, 1, 0);
    check("fullpp.full", 32'(full), 32'd1);
    check("fullpp.head", 32'(D_pop), 32'h0201);

    // Saturation and clear.
    for (int i = 0; i < 300; i++) step(1, 16'hFF00 + 16'(i & 255), 0, 0);
    check("sat.255", 32'(drop_cnt), 32'd255);
    step(0, 16'h0000, 0, 1);
    check("clr.ovf", 32'(ovf), 32'd0);
    check("clr.cnt", 32'(drop_cnt), 32'd0);
    step(1, 16'h0277, 0, 1);
    check("clrdrop.ovf", 32'(ovf), 32'd0);
    check("clrdrop.cnt", 32'(drop_cnt), 32'd1);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 3))
        0:       idb = 8'h02;
        1:       idb = 8'hFF;
        2:       idb = 8'h03;
        default: idb = 8'($urandom_range(0, 255));
      endcase
      d = {idb, 8'($urandom_range(0, 255))};
      step(logic'($urandom_range(0, 9) < 7), d, logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 49) == 0));
    end

    // Drain, fill 5, then asynchronous reset between edges.
    for (int i = 0; i < 20 && mq.size() > 0; i++) step(0, 16'h0000, 1, 0);
    check("drain.empty", 32'(mq.size()), 32'd0);
    for (int i = 0; i < 5; i++) step(1, 16'h0230 + 16'(i), 0, 0);
    check("pre_rst.pndng", 32'(pndng), 32'd1);
    #3 reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    check("async_rst.dpop", 32'(D_pop), 32'd0);
    reset = 1'b0;

    // Fresh head after reset, then 20 accepted and 5 foreign pushes for rx_cnt.
    step(1, 16'h02C3, 0, 0);
    check("fresh.head", 32'(D_pop), 32'h02C3);
    for (int i = 1; i < 20; i++) step(1, 16'hFF40 + 16'(i), 1, 0);
    for (int i = 0; i < 5; i++) step(1, 16'h0150 + 16'(i), 0, 0);
`ifdef RX_STATS_EN
    check("rx_cnt.20", 32'(rx_cnt), 32'd20);
`else
    check("rx_cnt.off", 32'(rx_cnt), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
